circle_shape_scheduler: RTL and testbench
=========================================

Name: circle_shape_scheduler

Overview:
Frame-synchronous controller that owns the endpoint registers feeding the circle renderer (x_in_1/y_in_1/x_in_2/y_in_2 plus valid_in of the renderer). It arbitrates circle-update requests from NUM_REQ requesters (e.g. camera detector, physics engine) round-robin and range-checks each request. Accepted shapes are held in a shadow register and committed only on a frame-start pulse, so the renderer never sees a mid-frame change.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..4.
H_ACTIVE, 1280, active width; any x >= H_ACTIVE is out of range.
V_ACTIVE, 720, active height; any y >= V_ACTIVE is out of range.

Ports:
clk_in  input  1  system clock.
rst_n_in  input  1  reset, asynchronous assert, active low.
frame_start_in  input  1  one-cycle pulse at hcount=0, vcount=0.
clear_in  input  1  one-cycle pulse requesting shape removal at next frame start.
req_valid_in  input  NUM_REQ  per-requester request valid.
req_x1_in  input  NUM_REQ*11  packed x1; requester i at [i*11 +: 11].
req_y1_in  input  NUM_REQ*10  packed y1; requester i at [i*10 +: 10].
req_x2_in  input  NUM_REQ*11  packed x2.
req_y2_in  input  NUM_REQ*10  packed y2.
req_ready_out  output  NUM_REQ  one-hot or zero grant.
x_out_1  output  11  committed x1 to renderer.
y_out_1  output  10  committed y1.
x_out_2  output  11  committed x2.
y_out_2  output  10  committed y2.
shape_valid_out  output  1  renderer valid_in; high while a committed shape exists.
committed_out  output  1  one-cycle pulse, cycle after a commit or clear takes effect.
reject_count_out  output  8  saturating count of rejected requests.
busy_out  output  1  high in PENDING.

Behaviour:
- Reset (rst_n_in low, async): all outputs 0; state IDLE; rr_ptr=0; shadow and pending_clear cleared. A reset mid-PENDING discards the shadow. No commit occurs.
- States: IDLE, PENDING.
- Grant in IDLE: scan requesters from rr_ptr upward with wrap. The first requester with valid=1 gets req_ready_out bit=1. All other bits are 0. req_ready_out depends combinationally on req_valid_in and state only, never on coordinates.
- Grant in PENDING: req_ready_out=0.
- Transfer: a transfer happens when valid&ready on a clock edge. On transfer, rr_ptr <= (granted index + 1) mod NUM_REQ, whether the request is accepted or rejected.
- Range check on the transfer cycle. Reject if any of these holds: x1>=H_ACTIVE, x2>=H_ACTIVE, y1>=V_ACTIVE, y2>=V_ACTIVE, or x1==x2 (zero radius).
- Rejected request: reject_count_out += 1, saturating at 255. State stays IDLE. The shadow is unchanged.
- Accepted request: coordinates are copied unmodified into the shadow (no min/max swap; the renderer normalises). State goes to PENDING.
- PENDING with frame_start_in=1:
  - On the next edge, {x_out_1,y_out_1,x_out_2,y_out_2} <= shadow, shape_valid_out <= 1, and state goes to IDLE.
  - committed_out is high for exactly the cycle after that edge.
- frame_start_in in IDLE with no pending_clear: ignored.
- A frame_start_in on the same edge as a transfer does not commit. The commit waits for the next frame_start_in.
- clear_in at any time sets pending_clear. At the next frame_start_in:
  - coordinate outputs <= 0, shape_valid_out <= 0, committed_out pulses;
  - if state is PENDING, the shadow is discarded and state goes to IDLE;
  - pending_clear is cleared.
  Clear wins over a pending shape. clear_in on the same edge as frame_start_in takes effect at the following frame start.
- Between commits, all coordinate outputs are stable for the whole frame. Latency from accepted transfer to output change is at most one frame period plus 1 cycle.
- Requesters must hold valid and data stable until ready. The block does not buffer more than one shape.

Test Plan:
- Reset then idle: hold rst_n_in=0 for 3 cycles, then release -> all outputs 0, req_ready_out=0 with no valid.
- Single request (1280x720 defaults): req0 sends x1=100,y1=200,x2=300,y2=200 -> ready[0]=1 in the same cycle, busy_out=1. On frame_start_in the outputs update the next cycle to 100/200/300/200 with shape_valid_out=1 and a 1-cycle committed_out.
- Round robin: both valid continuously; req0 is accepted, then a frame commit, then the next grant goes to req1 -> grants alternate 0,1,0,1 over 4 frames.
- Rejects: x1=x2=50, then x2=1280, then y1=720 -> 3 rejects, reject_count_out=3, outputs unchanged. Forcing 300 rejects -> count saturates at 255.
- Same-cycle race: a transfer on the same edge as frame_start_in -> no commit that frame; commit on the following frame_start_in.
- Clear vs pending: accept a shape, pulse clear_in, then frame_start_in -> shape_valid_out=0, outputs 0, state IDLE. Assert rst_n_in low mid-PENDING -> outputs 0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/circle_shape_scheduler.sv
// circle_shape_scheduler: round-robin arbiter + range check + frame-synchronous
//   commit of one circle shape into the renderer endpoint registers.
// Latency: grant is combinational in IDLE; accepted shape appears on the outputs
//   the cycle after the next frame_start_in edge (transfer-edge frame starts excluded).
// Backpressure: valid/ready per requester; ready is withheld while a shape is
//   pending, so at most one shape is ever buffered.
//
// Ports:
//   clk_in, rst_n_in           clock, async active-low reset
//   frame_start_in, clear_in   frame pulse, shape-removal request
//   req_valid_in/req_*_in      packed per-requester request (x 11 bits, y 10 bits)
//   req_ready_out              one-hot-or-zero grant
//   x_out_1..y_out_2           committed endpoints to the renderer
//   shape_valid_out            renderer valid; high while a committed shape exists
//   committed_out              one-cycle pulse after a commit or clear takes effect
//   reject_count_out           saturating rejected-request count
//   busy_out                   high while a shape waits for frame start

module circle_shape_scheduler #(
  parameter int NUM_REQ  = 2,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  frame_start_in,
  input  logic                  clear_in,
  input  logic [NUM_REQ-1:0]    req_valid_in,
  input  logic [NUM_REQ*11-1:0] req_x1_in,
  input  logic [NUM_REQ*10-1:0] req_y1_in,
  input  logic [NUM_REQ*11-1:0] req_x2_in,
  input  logic [NUM_REQ*10-1:0] req_y2_in,
  output logic [NUM_REQ-1:0]    req_ready_out,
  output logic [10:0]           x_out_1,
  output logic [9:0]            y_out_1,
  output logic [10:0]           x_out_2,
  output logic [9:0]            y_out_2,
  output logic                  shape_valid_out,
  output logic                  committed_out,
  output logic [7:0]            reject_count_out,
  output logic                  busy_out
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  typedef struct packed {
    logic [10:0] x1;
    logic [9:0]  y1;
    logic [10:0] x2;
    logic [9:0]  y2;
  } shape_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  shape_t        shadow;
  logic          pending_clear;

  // Arbiter results
  logic          grant_found;
  logic [PW-1:0] grant_idx;
  logic [PW:0]   cand;
  logic [PW-1:0] rr_next;

  // Granted requester's coordinates and range-check verdict
  shape_t        sel;
  logic          sel_reject;

  // Round-robin scan starting at rr_ptr. Coordinates never influence the grant;
  // a grant is only possible in IDLE and out of reset.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) begin
        cand = cand - (PW+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid_in[cand[PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PW-1:0];
      end
    end
    if (state != IDLE || !rst_n_in) begin
      grant_found = 1'b0;
    end
  end

  always_comb begin
    req_ready_out = '0;
    if (grant_found) begin
      req_ready_out = NUM_REQ'(1) << grant_idx;
    end
  end

  always_comb begin
    if (grant_idx == PW'(NUM_REQ-1)) begin
      rr_next = '0;
    end else begin
      rr_next = grant_idx + PW'(1);
    end
  end

  // Pick out the granted requester's fields from the packed buses.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PW'(i)) begin
        sel.x1 = req_x1_in[i*11 +: 11];
        sel.y1 = req_y1_in[i*10 +: 10];
        sel.x2 = req_x2_in[i*11 +: 11];
        sel.y2 = req_y2_in[i*10 +: 10];
      end
    end
  end

  // Out-of-frame endpoints or a zero horizontal radius are rejected.
  always_comb begin
    sel_reject = (int'(sel.x1) >= H_ACTIVE) ||
                 (int'(sel.x2) >= H_ACTIVE) ||
                 (int'(sel.y1) >= V_ACTIVE) ||
                 (int'(sel.y2) >= V_ACTIVE) ||
                 (sel.x1 == sel.x2);
  end

  assign busy_out = (state == PENDING);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      shadow           <= '0;
      pending_clear    <= 1'b0;
      x_out_1          <= '0;
      y_out_1          <= '0;
      x_out_2          <= '0;
      y_out_2          <= '0;
      shape_valid_out  <= 1'b0;
      committed_out    <= 1'b0;
      reject_count_out <= '0;
    end else begin
      committed_out <= 1'b0;

      // Frame-start side: a pending clear beats a pending shape. A clear_in
      // arriving on the same edge is kept for the following frame start.
      if (frame_start_in && pending_clear) begin
        x_out_1         <= '0;
        y_out_1         <= '0;
        x_out_2         <= '0;
        y_out_2         <= '0;
        shape_valid_out <= 1'b0;
        committed_out   <= 1'b1;
        pending_clear   <= clear_in;
        if (state == PENDING) begin
          shadow <= '0;
        end
      end else begin
        if (clear_in) begin
          pending_clear <= 1'b1;
        end
        if (frame_start_in && state == PENDING) begin
          x_out_1         <= shadow.x1;
          y_out_1         <= shadow.y1;
          x_out_2         <= shadow.x2;
          y_out_2         <= shadow.y2;
          shape_valid_out <= 1'b1;
          committed_out   <= 1'b1;
        end
      end

      // Request side. A transfer is only possible in IDLE, so it never
      // collides with a commit; a frame start on the transfer edge leaves the
      // new shape waiting for the next frame.
      if (grant_found) begin
        rr_ptr <= rr_next;
        if (sel_reject) begin
          if (reject_count_out != 8'hFF) begin
            reject_count_out <= reject_count_out + 8'd1;
          end
        end else begin
          shadow <= sel;
          state  <= PENDING;
        end
      end else if (frame_start_in && state == PENDING) begin
        state <= IDLE;
      end
    end
  end

`ifndef SYNTHESIS
  a_grant_onehot : assert property (@(posedge clk_in) disable iff (!rst_n_in)
    $onehot0(req_ready_out));
  a_no_grant_pending : assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (state == PENDING) |-> (req_ready_out == '0));
  a_grant_needs_valid : assert property (@(posedge clk_in) disable iff (!rst_n_in)
    ((req_ready_out & ~req_valid_in) == '0));
`endif

endmodule

// File: tb/tb_circle_shape_scheduler.sv
`timescale 1ns/1ps

module tb_circle_shape_scheduler;

  localparam int N  = 2;
  localparam int HA = 1280;
  localparam int VA = 720;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic            frame_start_in;
  logic            clear_in;
  logic [N-1:0]    req_valid_in;
  logic [N*11-1:0] req_x1_in;
  logic [N*10-1:0] req_y1_in;
  logic [N*11-1:0] req_x2_in;
  logic [N*10-1:0] req_y2_in;
  logic [N-1:0]    req_ready_out;
  logic [10:0]     x_out_1;
  logic [9:0]      y_out_1;
  logic [10:0]     x_out_2;
  logic [9:0]      y_out_2;
  logic            shape_valid_out;
  logic            committed_out;
  logic [7:0]      reject_count_out;
  logic            busy_out;

  always #5 clk_in = ~clk_in;

  circle_shape_scheduler #(.NUM_REQ(N), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .frame_start_in   (frame_start_in),
    .clear_in         (clear_in),
    .req_valid_in     (req_valid_in),
    .req_x1_in        (req_x1_in),
    .req_y1_in        (req_y1_in),
    .req_x2_in        (req_x2_in),
    .req_y2_in        (req_y2_in),
    .req_ready_out    (req_ready_out),
    .x_out_1          (x_out_1),
    .y_out_1          (y_out_1),
    .x_out_2          (x_out_2),
    .y_out_2          (y_out_2),
    .shape_valid_out  (shape_valid_out),
    .committed_out    (committed_out),
    .reject_count_out (reject_count_out),
    .busy_out         (busy_out)
  );

  typedef struct {
    int x1;
    int y1;
    int x2;
    int y2;
    bit sv;
  } shape_t;

  shape_t exp_q[$];
  shape_t mon_hold;
  int     glog[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     commit_seen = 0;

  // Requester-side stimulus state
  logic [N-1:0] rv;
  logic [10:0]  rx1 [N];
  logic [10:0]  rx2 [N];
  logic [9:0]   ry1 [N];
  logic [9:0]   ry2 [N];
  bit           auto_mode = 1'b0;

  // Reference model state
  int     m_rr;
  bit     m_pending;
  shape_t m_sh;
  bit     m_pclear;
  int     m_cnt;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic longint all_outs();
    return {x_out_1, y_out_1, x_out_2, y_out_2, shape_valid_out, committed_out,
            reject_count_out, busy_out, req_ready_out};
  endfunction

  task automatic post(input int i, input int x1, input int y1, input int x2, input int y2);
    rv[i]  = 1'b1;
    rx1[i] = 11'(x1);
    ry1[i] = 10'(y1);
    rx2[i] = 11'(x2);
    ry2[i] = 10'(y2);
  endtask

  task automatic rand_post(input int i);
    int x1, y1, x2, y2;
    x1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(HA, 2047)) : int'($urandom_range(0, HA-1));
    y1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(VA, 1023)) : int'($urandom_range(0, VA-1));
    x2 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(HA, 2047)) : int'($urandom_range(0, HA-1));
    y2 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(VA, 1023)) : int'($urandom_range(0, VA-1));
    if ($urandom_range(0, 7) == 0) x2 = x1;
    post(i, x1, y1, x2, y2);
  endtask

  task automatic do_reset();
    rst_n_in       = 1'b0;
    frame_start_in = 1'b0;
    clear_in       = 1'b0;
    req_valid_in   = '0;
    rv             = '0;
    m_rr      = 0;
    m_pending = 1'b0;
    m_pclear  = 1'b0;
    m_cnt     = 0;
    m_sh      = '{0, 0, 0, 0, 1'b0};
    mon_hold  = '{0, 0, 0, 0, 1'b0};
    exp_q.delete();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  // One clock cycle: check registered state, drive inputs, check the grant,
  // then advance the reference model across the coming edge.
  task automatic cycle(input bit fs, input bit cl);
    int     g;
    bit     acc;
    shape_t e;
    @(negedge clk_in);
    chk("busy", busy_out, m_pending);
    chk("reject_count", reject_count_out, m_cnt);
    if (auto_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) rand_post(i);
      end
    end
    frame_start_in = fs;
    clear_in       = cl;
    req_valid_in   = rv;
    for (int i = 0; i < N; i++) begin
      req_x1_in[i*11 +: 11] = rx1[i];
      req_y1_in[i*10 +: 10] = ry1[i];
      req_x2_in[i*11 +: 11] = rx2[i];
      req_y2_in[i*10 +: 10] = ry2[i];
    end
    #1;
    g = -1;
    if (!m_pending) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && rv[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    chk("req_ready", req_ready_out, (g < 0) ? 0 : (1 << g));

    if (fs && m_pclear) begin
      e = '{0, 0, 0, 0, 1'b0};
      exp_q.push_back(e);
      m_pending = 1'b0;
      m_pclear  = cl;
    end else begin
      if (cl) m_pclear = 1'b1;
      if (fs && m_pending) begin
        e    = m_sh;
        e.sv = 1'b1;
        exp_q.push_back(e);
        m_pending = 1'b0;
      end
    end

    if (g >= 0) begin
      glog.push_back(g);
      m_rr = (g + 1) % N;
      acc = (rx1[g] < HA) && (rx2[g] < HA) && (ry1[g] < VA) && (ry2[g] < VA) && (rx1[g] != rx2[g]);
      if (acc) begin
        m_sh      = '{int'(rx1[g]), int'(ry1[g]), int'(rx2[g]), int'(ry2[g]), 1'b1};
        m_pending = 1'b1;
      end else if (m_cnt < 255) begin
        m_cnt++;
      end
      rv[g] = 1'b0;
    end
  endtask

  // Monitor: pops an expected shape on every commit pulse and otherwise
  // requires the renderer outputs to stay at the last committed value.
  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_n_in === 1'b1) begin
        if (committed_out) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_commit", committed_out, 0);
          end else begin
            mon_hold = exp_q.pop_front();
            commit_seen++;
          end
        end
        chk("x_out_1", x_out_1, mon_hold.x1);
        chk("y_out_1", y_out_1, mon_hold.y1);
        chk("x_out_2", x_out_2, mon_hold.x2);
        chk("y_out_2", y_out_2, mon_hold.y2);
        chk("shape_valid", shape_valid_out, mon_hold.sv);
      end
    end
  end

  initial begin
    int c0;
    rst_n_in       = 1'b0;
    frame_start_in = 1'b0;
    clear_in       = 1'b0;
    req_valid_in   = '0;
    req_x1_in      = '0;
    req_y1_in      = '0;
    req_x2_in      = '0;
    req_y2_in      = '0;
    rv             = '0;
    for (int i = 0; i < N; i++) begin
      rx1[i] = '0; ry1[i] = '0; rx2[i] = '0; ry2[i] = '0;
    end
    m_rr = 0; m_pending = 1'b0; m_pclear = 1'b0; m_cnt = 0;
    m_sh = '{0, 0, 0, 0, 1'b0};
    mon_hold = '{0, 0, 0, 0, 1'b0};

    // Reset held for three cycles, then idle with no requests.
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset_outputs", all_outs(), 0);
    rst_n_in = 1'b1;
    cycle(0, 0);

    // Single request from requester 0, committed on the next frame start.
    post(0, 100, 200, 300, 200);
    c0 = commit_seen;
    cycle(0, 0);
    cycle(0, 0);
    cycle(1, 0);
    cycle(0, 0);
    chk("single_commit_count", commit_seen, c0 + 1);
    chk("single_x1", x_out_1, 100);
    chk("single_y1", y_out_1, 200);
    chk("single_x2", x_out_2, 300);
    chk("single_y2", y_out_2, 200);
    chk("single_valid", shape_valid_out, 1);

    // Round robin with both requesters continuously valid.
    do_reset();
    glog.delete();
    for (int f = 0; f < 4; f++) begin
      if (!rv[0]) post(0, 10 + f, 20, 40 + f, 30);
      if (!rv[1]) post(1, 500 + f, 60, 600 + f, 70);
      cycle(0, 0);
      cycle(1, 0);
      cycle(0, 0);
    end
    chk("rr_grants", glog.size() >= 4, 1);
    if (glog.size() >= 4) begin
      chk("rr_grant0", glog[0], 0);
      chk("rr_grant1", glog[1], 1);
      chk("rr_grant2", glog[2], 0);
      chk("rr_grant3", glog[3], 1);
    end
    rv = '0;
    cycle(1, 0);
    cycle(0, 0);

    // Rejects: zero radius, x out of range, y out of range; then saturation.
    post(0, 50, 10, 50, 20);
    cycle(0, 0);
    post(0, 10, 10, 1280, 20);
    cycle(0, 0);
    post(0, 10, 720, 20, 30);
    cycle(0, 0);
    cycle(0, 0);
    chk("reject_three", reject_count_out, 3);
    chk("reject_busy", busy_out, 0);
    repeat (300) begin
      post(0, 5, 5, 5, 5);
      cycle(0, 0);
    end
    cycle(0, 0);
    chk("reject_saturate", reject_count_out, 255);

    // Transfer on the same edge as frame start does not commit that frame.
    post(1, 400, 300, 500, 350);
    c0 = commit_seen;
    cycle(1, 0);
    repeat (3) cycle(0, 0);
    chk("race_no_commit", commit_seen, c0);
    cycle(1, 0);
    cycle(0, 0);
    chk("race_commit", commit_seen, c0 + 1);
    chk("race_x1", x_out_1, 400);

    // Clear beats a pending shape.
    post(0, 600, 100, 700, 150);
    cycle(0, 0);
    cycle(0, 1);
    cycle(1, 0);
    cycle(0, 0);
    chk("clear_valid", shape_valid_out, 0);
    chk("clear_x2", x_out_2, 0);
    chk("clear_busy", busy_out, 0);

    // Asynchronous reset while a shape is pending over a committed one.
    post(0, 20, 30, 40, 50);
    cycle(0, 0);
    cycle(1, 0);
    post(1, 70, 80, 90, 100);
    cycle(0, 0);
    @(negedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("async_reset", all_outs(), 0);
    do_reset();
    cycle(1, 0);
    cycle(0, 0);
    chk("no_commit_after_reset", shape_valid_out, 0);

    // Randomized traffic against the model.
    auto_mode = 1'b1;
    repeat (3000) begin
      cycle($urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0);
    end
    auto_mode = 1'b0;
    rv = '0;
    cycle(1, 0);
    cycle(0, 0);
    cycle(1, 0);
    cycle(0, 0);
    cycle(0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
